// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU built-in self-test controller.
package alu_bist_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, FINISH} state_t;

  localparam logic [15:0] MISR_POLY   = 16'h1021;
  localparam logic [15:0] MISR_SEED   = 16'hFFFF;
  localparam int          NUM_OPS_DEF = 15;
endpackage

// File: rtl/alu_bist_misr.sv
// 16-bit multiple-input signature register compacting ALU result and flags.
module alu_bist_misr
  import alu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [11:0] din,
  output logic [15:0] sig
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sig <= 16'h0000;
    else if (init) sig <= MISR_SEED;
    else if (en)   sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {4'b0, din};
  end
endmodule

// File: rtl/alu_bist.sv
// Sweeps every ALU opcode over one or two operand sets and compacts the
// results into a MISR signature that is compared against a golden value.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int NUM_OPS    = NUM_OPS_DEF,
  parameter int SETTLE     = 1,
  parameter int NUM_PASSES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  x_seed,
  input  logic [7:0]  y_seed,
  input  logic [15:0] golden,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_y,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  input  logic        alu_negative,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);
  state_t      state, state_n;
  logic [3:0]  sel, sel_n;
  logic        pidx, pidx_n;
  logic [7:0]  cnt, cnt_n;
  logic [7:0]  xs, ys, xs_n, ys_n;
  logic [7:0]  ax_n, ay_n;
  logic        init, en, drive_n;

  always_comb begin
    state_n = state;
    sel_n   = sel;
    pidx_n  = pidx;
    cnt_n   = cnt;
    xs_n    = xs;
    ys_n    = ys;
    init    = 1'b0;
    en      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = DRIVE;
        sel_n   = 4'd0;
        pidx_n  = 1'b0;
        cnt_n   = 8'd0;
        xs_n    = x_seed;
        ys_n    = y_seed;
        init    = 1'b1;
      end
      DRIVE: begin
        if (cnt == 8'(SETTLE - 1)) begin
          cnt_n   = 8'd0;
          state_n = CAPTURE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      CAPTURE: begin
        en = 1'b1;
        if (sel != 4'(NUM_OPS - 1)) begin
          sel_n   = sel + 4'd1;
          state_n = DRIVE;
        end else if (NUM_PASSES > 1 && !pidx) begin
          sel_n   = 4'd0;
          pidx_n  = 1'b1;
          state_n = DRIVE;
        end else begin
          state_n = FINISH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ALU operands are registered from next-state values so they line up with the state.
  assign drive_n = (state_n == DRIVE) || (state_n == CAPTURE);
  assign ax_n    = drive_n ? (pidx_n ? ~xs_n : xs_n) : 8'd0;
  assign ay_n    = drive_n ? (pidx_n ? ~ys_n : ys_n) : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= 4'd0;
      pidx    <= 1'b0;
      cnt     <= 8'd0;
      xs      <= 8'd0;
      ys      <= 8'd0;
      alu_x   <= 8'd0;
      alu_y   <= 8'd0;
      alu_sel <= 4'd0;
      pass    <= 1'b0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      pidx    <= pidx_n;
      cnt     <= cnt_n;
      xs      <= xs_n;
      ys      <= ys_n;
      alu_x   <= ax_n;
      alu_y   <= ay_n;
      alu_sel <= drive_n ? sel_n : 4'd0;
      if (state == FINISH) pass <= (signature == golden);
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  alu_bist_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (init),
    .en    (en),
    .din   ({alu_out, alu_zero, alu_carry, alu_overflow, alu_negative}),
    .sig   (signature)
  );
endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 Parameter NUM_OPS, default 15; number of opcodes swept, sel = 0..NUM_OPS-1 (max 16).
REQ-002 Parameter SETTLE, default 1; cycles each opcode is held on the ALU before its result is captured (min 1).
REQ-003 Parameter NUM_PASSES, default 2; number of operand sets swept (1 or 2).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  run request; sampled only in IDLE.
REQ-007 x_seed  in  8  first operand for pass 0; latched on an accepted start.
REQ-008 y_seed  in  8  second operand for pass 0; latched on an accepted start.
REQ-009 golden  in  16  expected signature; sampled in FINISH.
REQ-010 alu_x  out  8  operand x driven to the ALU.
REQ-011 alu_y  out  8  operand y driven to the ALU.
REQ-012 alu_sel  out  4  opcode driven to the ALU.
REQ-013 alu_out  in  8  ALU result.
REQ-014 alu_zero, alu_carry, alu_overflow, alu_negative  in  1 each  ALU flags.
REQ-015 busy  out  1  high from the cycle after an accepted start until FINISH, inclusive.
REQ-016 done  out  1  one-cycle pulse in FINISH.
REQ-017 pass  out  1  signature == golden; updated in FINISH and held.
REQ-018 signature  out  16  MISR contents; held after FINISH.

Function
REQ-019 The FSM SHALL have the states IDLE, DRIVE, CAPTURE and FINISH.
REQ-020 IDLE: on start=1, go to DRIVE; latch the seeds; set sel=0, pass index=0, settle count=0 and signature=16'hFFFF.
REQ-021 DRIVE: drive alu_x, alu_y and alu_sel from registers; after SETTLE cycles, go to CAPTURE.
REQ-022 CAPTURE (one cycle): update the MISR from the current ALU inputs, then:
  - if sel < NUM_OPS-1: sel++, go to DRIVE;
  - else if pass < NUM_PASSES-1: sel=0, pass++, go to DRIVE;
  - else: go to FINISH.
REQ-023 Operands: pass 0 uses x_seed/y_seed; pass 1 uses ~x_seed/~y_seed.
REQ-024 MISR update: sig_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {4'b0, alu_out, alu_zero, alu_carry, alu_overflow, alu_negative}.
REQ-025 FINISH (one cycle): done=1, pass=(signature==golden), busy=1, then go to IDLE.
REQ-026 Latency: done SHALL assert exactly NUM_PASSES*NUM_OPS*(SETTLE+1)+1 cycles after the edge that accepts start (61 with defaults).
REQ-027 start while not in IDLE SHALL be ignored, including start in FINISH; a start in the cycle following FINISH SHALL be accepted.
REQ-028 In IDLE, alu_x, alu_y and alu_sel SHALL be 0; signature and pass hold their last values.
REQ-029 ALU inputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-030 While rst_n=0: state=IDLE; busy, done, pass = 0; alu_x, alu_y, alu_sel = 0; signature=16'h0000.
REQ-031 Reset asserted mid-run SHALL abort the run immediately; no done pulse follows and no partial result is retained.

Structure
REQ-032 Package alu_bist_pkg SHALL hold the state enum, MISR_POLY=16'h1021, MISR_SEED=16'hFFFF and the default for NUM_OPS.
REQ-033 The MISR SHALL be a sub-module alu_bist_misr (clk, rst_n, init, en, din[11:0], sig[15:0]).

Verification
REQ-034 Reset check: assert rst_n=0 -> all outputs 0; release -> outputs stay 0 with start=0.
REQ-035 Sequence check, echo ALU stub: start with x_seed=25, y_seed=15 -> sel 0..14 at x=25, y=15, then sel 0..14 at x=230, y=240; each opcode held 2 cycles; busy high 61 cycles; done at cycle 61.
REQ-036 Compare check: run once and record signature S; rerun with golden=S -> pass=1 and signature==S (deterministic); rerun with golden=S^16'h0001 -> pass=0.
REQ-037 Flag sensitivity: stub forces alu_carry=1 only at sel=7 in pass 0 -> signature differs from the baseline S.
REQ-038 Busy start: pulse start at cycles 10 and 61 (FINISH) -> single run, one done; start at cycle 62 -> second run begins.
REQ-039 Reset mid-run: assert rst_n=0 at cycle 20 of a run -> busy=0, signature=0, no done within 100 cycles.
